// File: rtl/cmul_pipe.sv
// Pipelined signed complex multiplier y = a*b or a*conj(b), with valid/ready, rounding and overflow flag.
// Define CMUL_SAT_EN to clamp out-of-range components; otherwise they wrap to OUT_W bits.
module cmul_pipe #(
  parameter int IN_W     = 18,
  parameter int OUT_W    = 19,
  parameter int SHIFT    = 16,
  parameter int RND_MODE = 1
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    conj_i,
  input  logic signed [IN_W-1:0]  data_a_i_i,
  input  logic signed [IN_W-1:0]  data_a_q_i,
  input  logic signed [IN_W-1:0]  data_b_i_i,
  input  logic signed [IN_W-1:0]  data_b_q_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic signed [OUT_W-1:0] data_i_o,
  output logic signed [OUT_W-1:0] data_q_o,
  output logic                    ovf_o
);

  localparam int STAGES   = 4;
  localparam int PW       = 2*IN_W;
  localparam int SW       = PW + 1;
  localparam int RW       = SW + 1;
  localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [RW-1:0] RND_C = (RND_MODE != 0 && SHIFT > 0) ? (RW'(1) << SHIFT_M1) : '0;

  typedef struct packed {
    logic            conj;
    logic [IN_W-1:0] ai;
    logic [IN_W-1:0] aq;
    logic [IN_W-1:0] bi;
    logic [IN_W-1:0] bq;
  } req_t;

  typedef struct packed {
    logic          conj;
    logic [PW-1:0] ii;
    logic [PW-1:0] qq;
    logic [PW-1:0] iq;
    logic [PW-1:0] qi;
  } prod_t;

  logic              en;
  logic [STAGES-1:0] vld_pipe;
  req_t              s1_q;
  prod_t             s2_q;
  logic [1:0][SW-1:0]    sum_d, sum_q;
  logic [1:0][OUT_W-1:0] res;
  logic [1:0]            ovf;

  assign en      = !valid_o || ready_i;
  assign ready_o = en;
  assign valid_o = vld_pipe[STAGES-1];

  // Bubbles travel with the data; nothing collapses, the whole pipe freezes on en=0.
  always_ff @(posedge clk_i) begin
    if (srst_i)  vld_pipe <= '0;
    else if (en) vld_pipe <= {vld_pipe[STAGES-2:0], valid_i};
  end

  always_ff @(posedge clk_i) begin
    if (en && valid_i) begin
      s1_q.conj <= conj_i;
      s1_q.ai   <= data_a_i_i;
      s1_q.aq   <= data_a_q_i;
      s1_q.bi   <= data_b_i_i;
      s1_q.bq   <= data_b_q_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en && vld_pipe[0]) begin
      s2_q.conj <= s1_q.conj;
      s2_q.ii   <= PW'($signed(s1_q.ai)) * PW'($signed(s1_q.bi));
      s2_q.qq   <= PW'($signed(s1_q.aq)) * PW'($signed(s1_q.bq));
      s2_q.iq   <= PW'($signed(s1_q.ai)) * PW'($signed(s1_q.bq));
      s2_q.qi   <= PW'($signed(s1_q.aq)) * PW'($signed(s1_q.bi));
    end
  end

  logic signed [SW-1:0] e_ii, e_qq, e_iq, e_qi;
  assign e_ii = SW'($signed(s2_q.ii));
  assign e_qq = SW'($signed(s2_q.qq));
  assign e_iq = SW'($signed(s2_q.iq));
  assign e_qi = SW'($signed(s2_q.qi));

  assign sum_d[0] = s2_q.conj ? (e_ii + e_qq) : (e_ii - e_qq);
  assign sum_d[1] = s2_q.conj ? (e_qi - e_iq) : (e_iq + e_qi);

  // Sums get their own register so the add and the round/clamp chains sit in separate cycles.
  always_ff @(posedge clk_i) begin
    if (en && vld_pipe[1]) sum_q <= sum_d;
  end

  for (genvar g = 0; g < 2; g++) begin : g_rnd
    logic signed [RW-1:0]  rsum, r;
    logic [RW-OUT_W:0]     top;
    assign rsum   = $signed({sum_q[g][SW-1], sum_q[g]}) + $signed(RND_C);
    assign r      = rsum >>> SHIFT;
    // In range only if every bit from the OUT_W sign bit upward agrees.
    assign top    = r[RW-1:OUT_W-1];
    assign ovf[g] = !((&top) || !(|top));
`ifdef CMUL_SAT_EN
    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    assign res[g] = ovf[g] ? (r[RW-1] ? SAT_MIN : SAT_MAX) : r[OUT_W-1:0];
`else
    assign res[g] = r[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_i_o <= '0;
      data_q_o <= '0;
      ovf_o    <= 1'b0;
    end else if (en && vld_pipe[2]) begin
      data_i_o <= res[0];
      data_q_o <= res[1];
      ovf_o    <= |ovf;
    end
  end

endmodule

// File: tb/tb_cmul_pipe.sv
// Directed bench for cmul_pipe: latency, conj, rounding modes, overflow/wrap/clamp, stall and reset.
module tb_cmul_pipe;
  localparam int IN_W  = 18;
  localparam int OUT_W = 19;

  logic clk = 1'b0;
  logic srst, valid_i, conj, ready_i;
  logic signed [IN_W-1:0] ai, aq, bi, bq;
  logic ready_o, valid_o, ovf;
  logic signed [OUT_W-1:0] di, dq;
  logic t_ready_o, t_valid_o, t_ovf;
  logic signed [OUT_W-1:0] t_di, t_dq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cmul_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(16), .RND_MODE(1)) dut (
    .clk_i(clk), .srst_i(srst), .valid_i(valid_i), .ready_o(ready_o), .conj_i(conj),
    .data_a_i_i(ai), .data_a_q_i(aq), .data_b_i_i(bi), .data_b_q_i(bq),
    .valid_o(valid_o), .ready_i(ready_i), .data_i_o(di), .data_q_o(dq), .ovf_o(ovf));

  cmul_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(16), .RND_MODE(0)) dut_t (
    .clk_i(clk), .srst_i(srst), .valid_i(valid_i), .ready_o(t_ready_o), .conj_i(conj),
    .data_a_i_i(ai), .data_a_q_i(aq), .data_b_i_i(bi), .data_b_q_i(bq),
    .valid_o(t_valid_o), .ready_i(ready_i), .data_i_o(t_di), .data_q_o(t_dq), .ovf_o(t_ovf));

  task automatic drive(input int vai, input int vaq, input int vbi, input int vbq, input bit cj);
    ai = IN_W'(vai); aq = IN_W'(vaq); bi = IN_W'(vbi); bq = IN_W'(vbq);
    conj = cj; valid_i = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    srst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; conj = 1'b0;
    ai = '0; aq = '0; bi = '0; bq = '0;
    repeat (3) tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
    checks++; if (di !== 0 || dq !== 0) begin errors++; $display("FAIL reset_data got=(%0d,%0d) exp=(0,0)", di, dq); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", ready_o); end
    srst = 1'b0;
    tick();
  endtask

  task automatic test_latency;
    drive(65536, 0, 65536, 0, 1'b0);
    tick();
    valid_i = 1'b0;
    repeat (2) tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL latency_early got=%0b exp=0", valid_o); end
    tick();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL latency_k3 got=%0b exp=1", valid_o); end
    checks++; if (di !== 65536 || dq !== 0 || ovf !== 1'b0)
      begin errors++; $display("FAIL unity_mul got=(%0d,%0d,ovf=%0b) exp=(65536,0,ovf=0)", di, dq, ovf); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_no_dup got=%0b exp=0", valid_o); end
  endtask

  task automatic test_back_to_back;
    drive(0, 1, 0, 65536, 1'b0);
    tick();
    drive(0, 1, 0, 65536, 1'b1);
    tick();
    valid_i = 1'b0;
    repeat (2) tick();
    checks++; if (valid_o !== 1'b1 || di !== -1 || dq !== 0)
      begin errors++; $display("FAIL b2b_conj0 got=(v=%0b,%0d,%0d) exp=(v=1,-1,0)", valid_o, di, dq); end
    tick();
    checks++; if (valid_o !== 1'b1 || di !== 1 || dq !== 0)
      begin errors++; $display("FAIL b2b_conj1 got=(v=%0b,%0d,%0d) exp=(v=1,1,0)", valid_o, di, dq); end
    tick();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end got=%0b exp=0", valid_o); end
  endtask

  task automatic test_rounding;
    drive(1, 0, 32768, 0, 1'b0);
    tick();
    drive(-1, 0, 32768, 0, 1'b0);
    tick();
    valid_i = 1'b0;
    repeat (2) tick();
    checks++; if (di !== 1 || dq !== 0) begin errors++; $display("FAIL rnd_half_pos got=(%0d,%0d) exp=(1,0)", di, dq); end
    checks++; if (t_di !== 0 || t_dq !== 0) begin errors++; $display("FAIL trunc_half_pos got=(%0d,%0d) exp=(0,0)", t_di, t_dq); end
    tick();
    checks++; if (di !== 0 || dq !== 0) begin errors++; $display("FAIL rnd_half_neg got=(%0d,%0d) exp=(0,0)", di, dq); end
    checks++; if (t_di !== -1 || t_dq !== 0) begin errors++; $display("FAIL trunc_half_neg got=(%0d,%0d) exp=(-1,0)", t_di, t_dq); end
    tick();
  endtask

  task automatic test_overflow;
    // +131072 does not fit 18 bits signed: its encoding is -131072, which row 1 uses directly.
    int  v_ai[5]  = '{-131072, -131072, -131072, -131072, -131072};
    int  v_aq[5]  = '{-131072, -131072, -131072,       0,       0};
    int  v_bi[5]  = '{-131072, -131072,  131071, -131072, -131071};
    int  v_bq[5]  = '{-131072, -131072, -131072,       0,       0};
    bit  v_cj[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef CMUL_SAT_EN
    int  e_i[5]   = '{262143,      0, -262144,  262143, 262142};
    int  e_q[5]   = '{     0, 262143,       2,       0,      0};
`else
    int  e_i[5]   = '{     0,      0,       2, -262144, 262142};
    int  e_q[5]   = '{     0,      0,       2,       0,      0};
`endif
    bit  e_ovf[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    drive(v_ai[0], v_aq[0], v_bi[0], v_bq[0], v_cj[0]);
    for (int c = 0; c < 5 + 3; c++) begin
      tick();
      if (c + 1 < 5) drive(v_ai[c+1], v_aq[c+1], v_bi[c+1], v_bq[c+1], v_cj[c+1]);
      else valid_i = 1'b0;
      if (c >= 3) begin
        checks++;
        if (valid_o !== 1'b1 || di !== e_i[c-3] || dq !== e_q[c-3] || ovf !== e_ovf[c-3]) begin
          errors++;
          $display("FAIL ovf_vec%0d got=(v=%0b,%0d,%0d,ovf=%0b) exp=(v=1,%0d,%0d,ovf=%0b)",
                   c-3, valid_o, di, dq, ovf, e_i[c-3], e_q[c-3], e_ovf[c-3]);
        end
      end
    end
    checks++; if (t_ovf !== 1'b0 || t_di !== 262142)
      begin errors++; $display("FAIL trunc_edge got=(%0d,ovf=%0b) exp=(262142,ovf=0)", t_di, t_ovf); end
    tick();
  endtask

  task automatic test_stall;
    int  sent = 0, got = 0, cyc = 0;
    bit  prev_stall = 1'b0;
    logic signed [OUT_W-1:0] prev_di = '0, prev_dq = '0;
    while (got < 5 && cyc < 40) begin
      if (sent < 5) drive(sent + 1, -(sent + 1), 65536, 0, 1'b0);
      else valid_i = 1'b0;
      ready_i = !(cyc >= 4 && cyc < 8);
      #1;
      if (prev_stall) begin
        checks++;
        if (di !== prev_di || dq !== prev_dq) begin
          errors++; $display("FAIL stall_hold got=(%0d,%0d) exp=(%0d,%0d)", di, dq, prev_di, prev_dq);
        end
      end
      if (valid_o && !ready_i) begin
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got=%0b exp=0", ready_o); end
      end
      if (valid_o && ready_i) begin
        checks++;
        if (di !== got + 1 || dq !== -(got + 1)) begin
          errors++; $display("FAIL stream_%0d got=(%0d,%0d) exp=(%0d,%0d)", got, di, dq, got + 1, -(got + 1));
        end
        got++;
      end
      if (valid_i && ready_o) sent++;
      prev_stall = valid_o && !ready_i;
      prev_di = di; prev_dq = dq;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (got != 5) begin errors++; $display("FAIL stream_count got=%0d exp=5", got); end
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (4) begin
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_extra got=%0b exp=0", valid_o); end
    end
  endtask

  task automatic test_reset_flight;
    drive(7, 7, 65536, 0, 1'b0);
    tick();
    drive(8, 8, 65536, 0, 1'b0);
    tick();
    drive(9, 9, 65536, 0, 1'b0);
    tick();
    valid_i = 1'b0; srst = 1'b1;
    tick();
    srst = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flight_valid got=%0b exp=0", valid_o); end
    checks++; if (di !== 0 || dq !== 0 || ovf !== 1'b0)
      begin errors++; $display("FAIL flight_data got=(%0d,%0d,ovf=%0b) exp=(0,0,ovf=0)", di, dq, ovf); end
    repeat (6) begin
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flight_stale got=%0b exp=0", valid_o); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_rounding();
    test_overflow();
    test_stall();
    test_reset_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
